uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares one UartTx instance between NUM_SRC byte-stream sources.
- Grants the transmitter to one source per packet and issues one byte per UART frame time. It paces writes with an internal frame timer, because UartTx exposes no ready/busy output.
- Locks the grant until that source's last byte has been sent or its lock times out.
- Sits between the on-chip message producers (telemetry, debug, status) and the UartTx core that drives ck_io13.

---
 rtl/uart_tx_sched_pkg.sv | 28 ++
 rtl/uart_tx_sched_rr_arbiter.sv | 35 +++
 rtl/uart_tx_sched.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// uart_pkg: shared state encoding and timing helpers for the UART transmit scheduler.
// Revision: 1.0
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // One 10-bit frame plus idle guard bits.
  function automatic int byte_cycles(input int clk_freq, input int baud, input int guard_bits);
    return clks_per_bit(clk_freq, baud) * (10 + guard_bits);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: combinational first-one search over req, starting at ptr and wrapping.
// Revision: 1.0
`default_nettype none

module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int IDX_W   = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   gnt_o,
  output logic               any_o
);

  logic [IDX_W-1:0] idx;

  // Walk from the far end back to ptr so the last hit is the nearest one.
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = IDX_W'((int'(ptr_i) + i) % NUM_SRC);
      if (req_i[idx]) begin
        gnt_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin, packet-locked sharing of one UartTx between NUM_SRC byte sources.
// Revision: 1.0
`default_nettype none

module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int BAUD         = 115_200,
  parameter int NUM_SRC      = 4,
  parameter int GUARD_BITS   = 1,
  parameter int LOCK_TIMEOUT = 65_536
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         req_i,
  input  logic [NUM_SRC*8-1:0]       data_i,
  input  logic [NUM_SRC-1:0]         last_i,
  output logic [NUM_SRC-1:0]         ack_o,
  output logic [7:0]                 data_o,
  output logic                       wr_en_o,
  output logic [$clog2(NUM_SRC)-1:0] owner_o,
  output logic                       busy_o
);

  localparam int IDX_W     = idx_width(NUM_SRC);
  localparam int BYTE_CYC  = byte_cycles(CLK_FREQ, BAUD, GUARD_BITS);
  localparam int TIMER_W   = idx_width(BYTE_CYC);
  localparam int HOLD_W    = idx_width(LOCK_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BYTE_CYC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LOCK_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [7:0]           data_q, data_d;
  logic                 wr_en_q, wr_en_d;
  logic [NUM_SRC-1:0]   ack_q, ack_d;
  logic                 last_q, last_d;
  logic                 busy_q;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  logic [IDX_W-1:0]     arb_gnt;
  logic                 arb_any;
  logic                 issue;
  logic [IDX_W-1:0]     issue_idx;
  logic                 release_lock;
  logic                 owner_req;
  logic                 timer_done;
  logic                 hold_done;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .any_o (arb_any)
  );

  assign owner_req  = req_i[owner_q];
  assign timer_done = (timer_q == TIMER_LAST);
  assign hold_done  = (hold_q == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      ack_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      timer_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      busy_q  <= (state_d != IDLE);
      timer_q <= timer_d;
      hold_q  <= hold_d;
    end
  end

  // Next state plus the issue/release decisions the datapath acts on.
  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    issue_idx    = owner_q;
    release_lock = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          issue     = 1'b1;
          issue_idx = arb_gnt;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (timer_done) begin
          if (last_q) begin
            release_lock = 1'b1;
            state_d      = IDLE;
          end else if (owner_req) begin
            issue = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (owner_req) begin
          issue   = 1'b1;
          state_d = WAIT;
        end else if (hold_done) begin
          release_lock = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    ack_d   = '0;
    last_d  = last_q;
    rr_d    = rr_q;
    timer_d = (state_q == WAIT) ? timer_q + TIMER_W'(1) : timer_q;
    hold_d  = (state_q == HOLD) ? hold_q + HOLD_W'(1) : hold_q;

    if (issue) begin
      owner_d = issue_idx;
      data_d  = data_i[{issue_idx, 3'b000} +: 8];
      wr_en_d = 1'b1;
      ack_d   = NUM_SRC'(1) << issue_idx;
      last_d  = last_i[issue_idx];
      timer_d = '0;
    end

    if (release_lock) begin
      rr_d = (owner_q == IDX_W'(NUM_SRC - 1)) ? '0 : owner_q + IDX_W'(1);
    end

    if (state_q == WAIT && state_d == HOLD) begin
      hold_d = '0;
    end
  end

  assign ack_o   = ack_q;
  assign data_o  = data_q;
  assign wr_en_o = wr_en_q;
  assign owner_o = owner_q;
  assign busy_o  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed scenarios for the UART transmit scheduler (BYTE_CYCLES = 110).
// Revision: 1.0
`default_nettype none

module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  last;
  logic [3:0]  ack_o;
  logic [7:0]  data_o;
  logic        wr_en_o;
  logic [1:0]  owner_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_sched #(
    .CLK_FREQ     (1000),
    .BAUD         (100),
    .NUM_SRC      (4),
    .GUARD_BITS   (1),
    .LOCK_TIMEOUT (50)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .data_i  (data),
    .last_i  (last),
    .ack_o   (ack_o),
    .data_o  (data_o),
    .wr_en_o (wr_en_o),
    .owner_o (owner_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < budget && !ok) begin
      tick();
      cycles++;
      if (wr_en_o === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    data = '0;
    last = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    bit ok;
    bit bad;
    do_reset();
    rst = 1'b1;
    tick();
    n_cmp++; if (ack_o !== 4'h0)   begin n_bad++; $display("FAIL rst_ack: got %h want 0", ack_o); end
    n_cmp++; if (wr_en_o !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %b want 0", wr_en_o); end
    n_cmp++; if (busy_o !== 1'b0)  begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", data_o); end
    n_cmp++; if (owner_o !== 2'd0) begin n_bad++; $display("FAIL rst_owner: got %0d want 0", owner_o); end
    rst = 1'b0;
    req[2] = 1'b1; data[23:16] = 8'h5A; last[2] = 1'b0;
    wait_strobe(5, c, ok);
    n_cmp++; if (!ok || c !== 1) begin n_bad++; $display("FAIL first_grant_latency: got ok=%b cycles=%0d want 1", ok, c); end
    n_cmp++; if (owner_o !== 2'd2 || data_o !== 8'h5A) begin n_bad++; $display("FAIL first_grant: got owner=%0d data=%h want 2/5a", owner_o, data_o); end
    req = '0;
    repeat (20) tick();
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL busy_mid_wait: got %b want 1", busy_o); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if ({ack_o, wr_en_o, busy_o, data_o, owner_o} !== 15'd0)
      begin n_bad++; $display("FAIL async_rst_clear: got ack=%h wr=%b busy=%b data=%h owner=%0d want all 0", ack_o, wr_en_o, busy_o, data_o, owner_o); end
    tick();
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (busy_o !== 1'b0 || wr_en_o !== 1'b0) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_bad++; $display("FAIL idle_after_rst: got busy/strobe activity want none"); end
  endtask

  task automatic test_single_packet();
    int c;
    bit ok;
    int cb;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    do_reset();
    req[1] = 1'b1; data[15:8] = exp_b[0]; last[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(200, c, ok);
      if (k > 0) begin
        n_cmp++; if (!ok || c !== 110) begin n_bad++; $display("FAIL single_spacing%0d: got ok=%b cycles=%0d want 110", k, ok, c); end
      end
      n_cmp++; if (data_o !== exp_b[k] || ack_o !== 4'b0010 || owner_o !== 2'd1)
        begin n_bad++; $display("FAIL single_byte%0d: got data=%h ack=%b owner=%0d want %h/0010/1", k, data_o, ack_o, owner_o, exp_b[k]); end
      if (k < 2) begin
        data[15:8] = exp_b[k+1];
        last[1]    = (k == 1);
      end else begin
        req[1] = 1'b0;
      end
      if (k == 0) begin
        tick();
        c = 1;
        n_cmp++; if (wr_en_o !== 1'b0 || ack_o !== 4'h0) begin n_bad++; $display("FAIL strobe_width: got wr=%b ack=%b want 0/0000", wr_en_o, ack_o); end
        wait_strobe(200, cb, ok);
        n_cmp++; if (!ok || c + cb !== 110) begin n_bad++; $display("FAIL single_spacing1: got ok=%b cycles=%0d want 110", ok, c + cb); end
        n_cmp++; if (data_o !== exp_b[1] || ack_o !== 4'b0010) begin n_bad++; $display("FAIL single_byte1: got data=%h ack=%b want 42/0010", data_o, ack_o); end
        data[15:8] = exp_b[2];
        last[1]    = 1'b1;
        k = 1;
      end
    end
    c = 0;
    while (c < 200 && busy_o === 1'b1) begin tick(); c++; end
    n_cmp++; if (c !== 110) begin n_bad++; $display("FAIL single_busy_fall: got %0d cycles want 110", c); end
    n_cmp++; if (data_o !== 8'h43) begin n_bad++; $display("FAIL data_hold: got %h want 43", data_o); end
  endtask

  task automatic test_round_robin();
    int c;
    bit ok;
    logic [1:0] exp_o [4];
    exp_o[0] = 2'd0; exp_o[1] = 2'd2; exp_o[2] = 2'd0; exp_o[3] = 2'd2;
    do_reset();
    rst = 1'b1;
    req = 4'b0101; data[7:0] = 8'hA0; data[23:16] = 8'hA2; last = 4'b0101;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(200, c, ok);
      if (k > 0) begin
        n_cmp++; if (!ok || c !== 111) begin n_bad++; $display("FAIL rr_spacing%0d: got ok=%b cycles=%0d want 111", k, ok, c); end
      end
      n_cmp++; if (owner_o !== exp_o[k] || data_o !== {6'b101000, exp_o[k]})
        begin n_bad++; $display("FAIL rr_grant%0d: got owner=%0d data=%h want %0d/%h", k, owner_o, data_o, exp_o[k], {6'b101000, exp_o[k]}); end
    end
    req = '0;
  endtask

  task automatic test_lock();
    int c;
    bit ok;
    bit bad;
    do_reset();
    req = 4'b1001; data[7:0] = 8'h10; data[31:24] = 8'h33; last = 4'b1000;
    wait_strobe(5, c, ok);
    n_cmp++; if (!ok || owner_o !== 2'd0 || data_o !== 8'h10) begin n_bad++; $display("FAIL lock_first: got ok=%b owner=%0d data=%h want 0/10", ok, owner_o, data_o); end
    req[0] = 1'b0; data[7:0] = 8'h11; last[0] = 1'b1;
    bad = 1'b0;
    repeat (140) begin
      tick();
      if (wr_en_o !== 1'b0) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_bad++; $display("FAIL lock_hold_quiet: got a strobe during hold want none"); end
    req[0] = 1'b1;
    wait_strobe(5, c, ok);
    n_cmp++; if (!ok || c !== 1) begin n_bad++; $display("FAIL lock_resume_latency: got ok=%b cycles=%0d want 1", ok, c); end
    n_cmp++; if (owner_o !== 2'd0 || data_o !== 8'h11 || ack_o !== 4'b0001)
      begin n_bad++; $display("FAIL lock_second: got owner=%0d data=%h ack=%b want 0/11/0001", owner_o, data_o, ack_o); end
    req[0] = 1'b0;
    wait_strobe(200, c, ok);
    n_cmp++; if (!ok || c !== 111 || owner_o !== 2'd3 || data_o !== 8'h33)
      begin n_bad++; $display("FAIL lock_next_src: got ok=%b cycles=%0d owner=%0d data=%h want 111/3/33", ok, c, owner_o, data_o); end
    req = '0;
  endtask

  task automatic test_timeout();
    int c;
    bit ok;
    bit bad;
    do_reset();
    req = 4'b0110; data[15:8] = 8'h71; data[23:16] = 8'h72; last = 4'b0100;
    wait_strobe(5, c, ok);
    n_cmp++; if (!ok || owner_o !== 2'd1 || data_o !== 8'h71) begin n_bad++; $display("FAIL to_first: got ok=%b owner=%0d data=%h want 1/71", ok, owner_o, data_o); end
    req[1] = 1'b0;
    bad = 1'b0;
    repeat (159) begin
      tick();
      if (wr_en_o !== 1'b0 || busy_o !== 1'b1) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_bad++; $display("FAIL to_locked: got strobe or idle before timeout want locked"); end
    tick();
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL to_release: got busy=%b want 0", busy_o); end
    wait_strobe(3, c, ok);
    n_cmp++; if (!ok || c !== 1 || owner_o !== 2'd2 || data_o !== 8'h72)
      begin n_bad++; $display("FAIL to_next_src: got ok=%b cycles=%0d owner=%0d data=%h want 1/2/72", ok, c, owner_o, data_o); end
    req = '0;
  endtask

  task automatic test_release_race();
    int c;
    bit ok;
    do_reset();
    req = 4'b0001; data[7:0] = 8'hB0; last = 4'b0011; data[15:8] = 8'hC1;
    wait_strobe(5, c, ok);
    n_cmp++; if (!ok || owner_o !== 2'd0 || data_o !== 8'hB0) begin n_bad++; $display("FAIL race_first: got ok=%b owner=%0d data=%h want 0/b0", ok, owner_o, data_o); end
    req[0] = 1'b0; data[7:0] = 8'hB1;
    repeat (109) tick();
    req = 4'b0011;
    wait_strobe(5, c, ok);
    n_cmp++; if (!ok || c !== 2 || owner_o !== 2'd1 || data_o !== 8'hC1)
      begin n_bad++; $display("FAIL race_winner: got ok=%b cycles=%0d owner=%0d data=%h want 2/1/c1", ok, c, owner_o, data_o); end
    req = '0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    data = '0;
    last = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_lock();
    test_timeout();
    test_release_race();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
